// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//
// Serial transmitter for the 8N1 frame format. The frame is one start bit (0),
// then eight data bits sent LSB first, then one stop bit (1). There is no
// parity bit.
//
// Every output comes straight from a flop. Each register's next value is
// computed in one combinational block and loaded on the rising clock edge.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit period (2..65535)
//
// Ports:
//   clk       system clock, rising-edge active
//   rst       asynchronous active-high reset
//   tx_start  send request, sampled on each rising edge while idle
//   tx_data   byte to send, captured only on the accepting edge
//   tx_out    serial line, idle/mark level is 1
//   tx_busy   high while a frame is in progress
//   tx_done   one-cycle pulse in the first idle cycle after a frame
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       idx_r, idx_s;
    logic [7:0]       shreg_r, shreg_s;
    logic             out_r, out_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             wrap_s;

    // Next-state and next-output logic. The line level, busy and done are
    // computed here one cycle early so that they can come straight from flops.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        shreg_s = shreg_r;
        out_s   = out_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        wrap_s  = (cnt_r == LAST_CNT);

        case (state_r)
            IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                idx_s = 3'd0;
                if (tx_start) begin
                    state_s = START;
                    shreg_s = tx_data;
                    out_s   = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                    out_s   = 1'b1;
                    busy_s  = 1'b0;
                end
            end

            START: begin
                if (wrap_s) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = DATA;
                    out_s   = shreg_r[0];
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end

            DATA: begin
                if (wrap_s) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (idx_r == 3'd7) begin
                        state_s = STOP;
                        out_s   = 1'b1;
                    end else begin
                        // The bit on the line is always shreg_r[0]. Shift the
                        // register and present the bit that moves down next.
                        idx_s   = idx_r + 3'd1;
                        shreg_s = {1'b0, shreg_r[7:1]};
                        out_s   = shreg_r[1];
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end

            STOP: begin
                if (wrap_s) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = IDLE;
                    out_s   = 1'b1;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end

            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
                idx_s   = 3'd0;
                out_s   = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset forces the line to mark at once,
    // which aborts any frame in progress without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= 3'd0;
            shreg_r <= 8'h00;
            out_r   <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shreg_r <= shreg_s;
            out_r   <= out_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign tx_out  = out_r;
    assign tx_busy = busy_r;
    assign tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//
// Testbench for uart_tx. It drives two instances, one with 10 clocks per bit
// and one with 2 clocks per bit. A timeline model predicts the line level,
// busy and done for every cycle. The model works from two facts: the cycle on
// which each frame was accepted, and which bit of the 10-bit frame should be
// on the line at a given offset from that cycle.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    logic            clk;
    logic            rst;
    logic [1:0]      start_s;
    logic [1:0][7:0] data_s;
    logic [1:0]      out_s;
    logic [1:0]      busy_s;
    logic [1:0]      done_s;

    int pass_cnt;
    int chk_cnt;

    uart_tx #(.CLKS_PER_BIT(10)) dut10 (
        .clk(clk), .rst(rst), .tx_start(start_s[0]), .tx_data(data_s[0]),
        .tx_out(out_s[0]), .tx_busy(busy_s[0]), .tx_done(done_s[0])
    );

    uart_tx #(.CLKS_PER_BIT(2)) dut2 (
        .clk(clk), .rst(rst), .tx_start(start_s[1]), .tx_data(data_s[1]),
        .tx_out(out_s[1]), .tx_busy(busy_s[1]), .tx_done(done_s[1])
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timeline model state, one slot per instance.
    int        cpb [2] = '{10, 2};
    int        cyc;
    bit        active_m [2];
    int        acc_m [2];
    bit [7:0]  byte_m [2];
    bit        done_m [2];

    initial begin
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            active_m[d] = 1'b0;
            acc_m[d]    = 0;
            byte_m[d]   = 8'h00;
            done_m[d]   = 1'b0;
        end
    end

    // Advance the model on every rising edge. A frame ends after exactly
    // 10*cpb cycles. A new request is considered only when no frame is active.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            done_m[d] = 1'b0;
            if (rst) begin
                active_m[d] = 1'b0;
            end else if (active_m[d]) begin
                if (cyc - acc_m[d] == 10 * cpb[d]) begin
                    active_m[d] = 1'b0;
                    done_m[d]   = 1'b1;
                end
            end else if (start_s[d]) begin
                active_m[d] = 1'b1;
                acc_m[d]    = cyc;
                byte_m[d]   = data_s[d];
            end
        end
    end

    // Line level expected by the model for instance d at this moment.
    function automatic bit exp_line(int d);
        int k;
        if (rst || !active_m[d]) return 1'b1;
        k = (cyc - acc_m[d]) / cpb[d];
        if (k == 0) return 1'b0;
        if (k <= 8) return byte_m[d][k-1];
        return 1'b1;
    endfunction

    // Record one comparison, and print a FAIL line if it does not match.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Compare both instances against the model.
    task automatic check_cycle();
        check("tx_out cpb10",  {31'd0, out_s[0]},  {31'd0, exp_line(0)});
        check("tx_busy cpb10", {31'd0, busy_s[0]}, {31'd0, (!rst && active_m[0])});
        check("tx_done cpb10", {31'd0, done_s[0]}, {31'd0, (!rst && done_m[0])});
        check("tx_out cpb2",   {31'd0, out_s[1]},  {31'd0, exp_line(1)});
        check("tx_busy cpb2",  {31'd0, busy_s[1]}, {31'd0, (!rst && active_m[1])});
        check("tx_done cpb2",  {31'd0, done_s[1]}, {31'd0, (!rst && done_m[1])});
    endtask

    // Run n cycles. Outputs are checked on each falling edge, and the task
    // returns 1 time unit after the following rising edge, ready for new inputs.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            check_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    int busy_n;
    int done_n;
    int waited;

    // Directed scenarios first, then randomized traffic on both instances.
    initial begin
        pass_cnt   = 0;
        chk_cnt    = 0;
        rst        = 1'b1;
        start_s    = 2'b00;
        data_s[0]  = 8'h00;
        data_s[1]  = 8'h00;
        step(3);
        rst = 1'b0;
        step(2);

        // Send 0xA5 and measure the busy window and the done pulse.
        data_s[0] = 8'hA5; start_s[0] = 1'b1;
        step(1);
        start_s[0] = 1'b0;
        busy_n = 1; done_n = 0;
        for (int i = 0; i < 110; i++) begin
            step(1);
            busy_n += int'(busy_s[0]);
            done_n += int'(done_s[0]);
        end
        check("a5 busy length", busy_n, 100);
        check("a5 done pulses", done_n, 1);

        // Assert reset part way through a frame, then send a full frame.
        data_s[0] = 8'($urandom); start_s[0] = 1'b1;
        step(1);
        start_s[0] = 1'b0;
        step(36);
        rst = 1'b1;
        step(2);
        rst = 1'b0; data_s[0] = 8'($urandom); start_s[0] = 1'b1;
        step(1);
        start_s[0] = 1'b0;
        step(105);

        // A request during a frame is ignored.
        data_s[0] = 8'h3C; start_s[0] = 1'b1;
        step(1);
        start_s[0] = 1'b0;
        step(49);
        data_s[0] = 8'h00; start_s[0] = 1'b1;
        step(1);
        start_s[0] = 1'b0;
        step(60);

        // Hold the request high and change the data in the done cycle.
        data_s[0] = 8'h55; start_s[0] = 1'b1;
        waited = 0;
        step(1);
        while (!done_s[0] && waited < 300) begin
            step(1);
            waited++;
        end
        check("done seen before timeout", {31'd0, done_s[0]}, 32'd1);
        data_s[0] = 8'hFF;
        step(1);
        start_s[0] = 1'b0;
        step(110);

        // Data changes after acceptance must not reach the line.
        data_s[0] = 8'h81; start_s[0] = 1'b1;
        step(1);
        start_s[0] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            data_s[0] = 8'($urandom);
            step(1);
        end
        step(10);

        // Two clocks per bit: send 0xFF, then 0x00, then back-to-back frames.
        data_s[1] = 8'hFF; start_s[1] = 1'b1;
        step(1);
        start_s[1] = 1'b0;
        step(22);
        data_s[1] = 8'h00; start_s[1] = 1'b1;
        step(1);
        start_s[1] = 1'b0;
        step(22);
        start_s[1] = 1'b1;
        for (int i = 0; i < 80; i++) begin
            data_s[1] = 8'($urandom);
            step(1);
        end
        start_s[1] = 1'b0;
        step(25);

        // Randomized traffic, with an occasional one-cycle reset.
        for (int i = 0; i < 3000; i++) begin
            start_s[0] = ($urandom_range(0, 15) == 0);
            start_s[1] = ($urandom_range(0, 3) == 0);
            data_s[0]  = 8'($urandom);
            data_s[1]  = 8'($urandom);
            rst        = ($urandom_range(0, 399) == 0);
            step(1);
        end
        rst = 1'b0; start_s = 2'b00;
        step(120);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
